// File: rtl/kanny_pipe_pkg.sv
// Shared constants and types for the KannyMIPS inter-stage registers.
// Stall encoding, reset level, write-disable level and NOP register/data words.
package kanny_pipe_pkg;

    localparam logic        STOP          = 1'b1;
    localparam logic        NO_STOP       = 1'b0;
    localparam logic        RST_ENABLE    = 1'b1;
    localparam logic        WRITE_DISABLE = 1'b0;
    localparam logic [4:0]  NOP_REG_ADDR  = 5'd0;
    localparam logic [31:0] ZERO_WORD     = 32'h0000_0000;

    typedef enum logic [1:0] {
        CAP_ADVANCE,
        CAP_BUBBLE,
        CAP_HOLD
    } cap_e;

endpackage

// File: rtl/wb_conflict_filter.sv
// Write-back enable filter: drops $0 writes, resolves duplicate addresses
// in favour of the lowest channel, and masks everything for non-valid slots.
module wb_conflict_filter
    import kanny_pipe_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int ADDR_W = 5
) (
    input  logic                     valid,
    input  logic [NUM_CH-1:0]        wen,
    input  logic [NUM_CH*ADDR_W-1:0] waddr,
    output logic [NUM_CH-1:0]        wen_f,
    output logic                     conflict
);

    logic [NUM_CH-1:0] nz;
    logic [NUM_CH-1:0] drop;

    always_comb begin
        nz   = '0;
        drop = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            nz[i] = wen[i] && (waddr[i*ADDR_W +: ADDR_W] != '0);
        end
        // a later channel loses to any earlier enabled one on the same register
        for (int i = 1; i < NUM_CH; i++) begin
            for (int j = 0; j < i; j++) begin
                if (nz[i] && nz[j] &&
                    waddr[i*ADDR_W +: ADDR_W] == waddr[j*ADDR_W +: ADDR_W]) begin
                    drop[i] = 1'b1;
                end
            end
        end
        conflict = |drop;
        wen_f    = valid ? (nz & ~drop) : {NUM_CH{WRITE_DISABLE}};
    end

endmodule

// File: rtl/mem_wb_multi.sv
// MEM/WB pipeline register with NUM_CH write-back channels, stall/flush
// handling and saturating bubble/hold performance counters.
module mem_wb_multi
    import kanny_pipe_pkg::*;
#(
    parameter int NUM_CH  = 2,
    parameter int ADDR_W  = 5,
    parameter int DATA_W  = 32,
    parameter int STALL_W = 6,
    parameter int STAGE   = 4,
    parameter int PERF_W  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [STALL_W-1:0]       stall,
    input  logic                     flush,
    input  logic                     cnt_clr,
    input  logic                     valid_i,
    input  logic [31:0]              pc_i,
    input  logic [NUM_CH-1:0]        wen_i,
    input  logic [NUM_CH*ADDR_W-1:0] waddr_i,
    input  logic [NUM_CH*DATA_W-1:0] wdata_i,
    output logic                     valid_o,
    output logic [31:0]              pc_o,
    output logic [NUM_CH-1:0]        wen_o,
    output logic [NUM_CH*ADDR_W-1:0] waddr_o,
    output logic [NUM_CH*DATA_W-1:0] wdata_o,
    output logic                     conflict_o,
    output logic [PERF_W-1:0]        bubble_cnt_o,
    output logic [PERF_W-1:0]        hold_cnt_o
);

    logic [NUM_CH-1:0] wen_f;
    logic              conflict_f;
    cap_e              cap;
    logic              stall_unused;

    assign stall_unused = ^stall;

    wb_conflict_filter #(
        .NUM_CH (NUM_CH),
        .ADDR_W (ADDR_W)
    ) u_filter (
        .valid    (valid_i),
        .wen      (wen_i),
        .waddr    (waddr_i),
        .wen_f    (wen_f),
        .conflict (conflict_f)
    );

    // flush outranks any stall combination
    always_comb begin
        if (flush)
            cap = CAP_BUBBLE;
        else if (stall[STAGE] == NO_STOP)
            cap = CAP_ADVANCE;
        else if (stall[STAGE+1] == NO_STOP)
            cap = CAP_BUBBLE;
        else
            cap = CAP_HOLD;
    end

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            valid_o    <= 1'b0;
            pc_o       <= ZERO_WORD;
            wen_o      <= {NUM_CH{WRITE_DISABLE}};
            waddr_o    <= '0;
            wdata_o    <= '0;
            conflict_o <= 1'b0;
        end else begin
            unique case (cap)
                CAP_ADVANCE: begin
                    valid_o    <= valid_i;
                    pc_o       <= pc_i;
                    wen_o      <= wen_f;
                    waddr_o    <= waddr_i;
                    wdata_o    <= wdata_i;
                    conflict_o <= conflict_f;
                end
                CAP_BUBBLE: begin
                    valid_o    <= 1'b0;
                    pc_o       <= ZERO_WORD;
                    wen_o      <= {NUM_CH{WRITE_DISABLE}};
                    waddr_o    <= '0;
                    wdata_o    <= '0;
                    conflict_o <= 1'b0;
                end
                default: begin
                    valid_o    <= valid_o;
                    pc_o       <= pc_o;
                    wen_o      <= wen_o;
                    waddr_o    <= waddr_o;
                    wdata_o    <= wdata_o;
                    conflict_o <= conflict_o;
                end
            endcase
        end
    end

    // saturating counters; clear beats increment
    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE || cnt_clr) begin
            bubble_cnt_o <= '0;
            hold_cnt_o   <= '0;
        end else begin
            if (cap == CAP_BUBBLE && bubble_cnt_o != '1)
                bubble_cnt_o <= bubble_cnt_o + 1'b1;
            if (cap == CAP_HOLD && hold_cnt_o != '1)
                hold_cnt_o <= hold_cnt_o + 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_wb_multi.sv
// Directed table-driven bench for mem_wb_multi (NUM_CH=2, PERF_W=4).
// Each vector is one clock edge; outputs are compared 1 ns after the edge.
module tb_mem_wb_multi;

    localparam int NUM_CH = 2;
    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;
    localparam int PERF_W = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall;
    logic        flush;
    logic        cnt_clr;
    logic        valid_i;
    logic [31:0] pc_i;
    logic [1:0]  wen_i;
    logic [9:0]  waddr_i;
    logic [63:0] wdata_i;
    logic        valid_o;
    logic [31:0] pc_o;
    logic [1:0]  wen_o;
    logic [9:0]  waddr_o;
    logic [63:0] wdata_o;
    logic        conflict_o;
    logic [3:0]  bubble_cnt_o;
    logic [3:0]  hold_cnt_o;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mem_wb_multi #(
        .NUM_CH  (NUM_CH),
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .STALL_W (6),
        .STAGE   (4),
        .PERF_W  (PERF_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .flush        (flush),
        .cnt_clr      (cnt_clr),
        .valid_i      (valid_i),
        .pc_i         (pc_i),
        .wen_i        (wen_i),
        .waddr_i      (waddr_i),
        .wdata_i      (wdata_i),
        .valid_o      (valid_o),
        .pc_o         (pc_o),
        .wen_o        (wen_o),
        .waddr_o      (waddr_o),
        .wdata_o      (wdata_o),
        .conflict_o   (conflict_o),
        .bubble_cnt_o (bubble_cnt_o),
        .hold_cnt_o   (hold_cnt_o)
    );

    typedef struct {
        logic [5:0]  stall;
        logic        flush;
        logic        clr;
        logic        valid;
        logic [31:0] pc;
        logic [1:0]  wen;
        logic [9:0]  waddr;
        logic [63:0] wdata;
        logic        e_valid;
        logic [31:0] e_pc;
        logic [1:0]  e_wen;
        logic [9:0]  e_waddr;
        logic [63:0] e_wdata;
        logic        e_conf;
        logic [3:0]  e_bub;
        logic [3:0]  e_hold;
    } vec_t;

    vec_t tbl[13];

    function automatic vec_t mk(
        input logic [5:0] st, input logic fl, input logic cl,
        input logic v, input logic [31:0] pc, input logic [1:0] w,
        input logic [9:0] a, input logic [63:0] d,
        input logic ev, input logic [31:0] epc, input logic [1:0] ew,
        input logic [9:0] ea, input logic [63:0] ed,
        input logic ec, input logic [3:0] eb, input logic [3:0] eh);
        vec_t r;
        r.stall = st; r.flush = fl; r.clr = cl; r.valid = v;
        r.pc = pc; r.wen = w; r.waddr = a; r.wdata = d;
        r.e_valid = ev; r.e_pc = epc; r.e_wen = ew; r.e_waddr = ea;
        r.e_wdata = ed; r.e_conf = ec; r.e_bub = eb; r.e_hold = eh;
        return r;
    endfunction

    task automatic drive(input vec_t v);
        stall   = v.stall;
        flush   = v.flush;
        cnt_clr = v.clr;
        valid_i = v.valid;
        pc_i    = v.pc;
        wen_i   = v.wen;
        waddr_i = v.waddr;
        wdata_i = v.wdata;
    endtask

    task automatic check(input string nm, input vec_t v);
        bit bad = 0;
        n_vec++;
        if (valid_o !== v.e_valid) begin
            bad = 1;
            $display("FAIL %s valid_o got %b want %b", nm, valid_o, v.e_valid);
        end
        if (pc_o !== v.e_pc) begin
            bad = 1;
            $display("FAIL %s pc_o got %h want %h", nm, pc_o, v.e_pc);
        end
        if (wen_o !== v.e_wen) begin
            bad = 1;
            $display("FAIL %s wen_o got %b want %b", nm, wen_o, v.e_wen);
        end
        if (waddr_o !== v.e_waddr) begin
            bad = 1;
            $display("FAIL %s waddr_o got %h want %h", nm, waddr_o, v.e_waddr);
        end
        if (wdata_o !== v.e_wdata) begin
            bad = 1;
            $display("FAIL %s wdata_o got %h want %h", nm, wdata_o, v.e_wdata);
        end
        if (conflict_o !== v.e_conf) begin
            bad = 1;
            $display("FAIL %s conflict_o got %b want %b", nm, conflict_o, v.e_conf);
        end
        if (bubble_cnt_o !== v.e_bub) begin
            bad = 1;
            $display("FAIL %s bubble_cnt got %0d want %0d", nm, bubble_cnt_o, v.e_bub);
        end
        if (hold_cnt_o !== v.e_hold) begin
            bad = 1;
            $display("FAIL %s hold_cnt got %0d want %0d", nm, hold_cnt_o, v.e_hold);
        end
        if (bad) n_bad++;
    endtask

    task automatic step(input string nm, input vec_t v);
        drive(v);
        @(posedge clk);
        #1;
        check(nm, v);
    endtask

    localparam logic [5:0] ADV  = 6'b000000;
    localparam logic [5:0] BUB  = 6'b010000;
    localparam logic [5:0] HOLD = 6'b110000;

    initial begin
        vec_t zero;
        vec_t v;
        zero = mk(ADV, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // stimulus -> expected after the edge
        tbl[0]  = mk(ADV, 0, 0, 1, 32'h100, 2'b01, {5'd0, 5'd5}, {32'h0, 32'h1234},
                     1, 32'h100, 2'b01, {5'd0, 5'd5}, {32'h0, 32'h1234}, 0, 0, 0);
        tbl[1]  = mk(ADV, 0, 0, 1, 32'h104, 2'b11, {5'd7, 5'd7}, {32'hAAAA, 32'hBBBB},
                     1, 32'h104, 2'b01, {5'd7, 5'd7}, {32'hAAAA, 32'hBBBB}, 1, 0, 0);
        tbl[2]  = mk(ADV, 0, 0, 1, 32'h108, 2'b11, {5'd3, 5'd0}, {32'h33, 32'h44},
                     1, 32'h108, 2'b10, {5'd3, 5'd0}, {32'h33, 32'h44}, 0, 0, 0);
        tbl[3]  = mk(ADV, 0, 0, 0, 32'h10C, 2'b11, {5'd2, 5'd1}, {32'h5, 32'h6},
                     0, 32'h10C, 2'b00, {5'd2, 5'd1}, {32'h5, 32'h6}, 0, 0, 0);
        tbl[4]  = mk(ADV, 0, 0, 1, 32'h110, 2'b11, {5'd9, 5'd4}, {32'h99, 32'h44},
                     1, 32'h110, 2'b11, {5'd9, 5'd4}, {32'h99, 32'h44}, 0, 0, 0);
        tbl[5]  = mk(HOLD, 0, 0, 1, 32'h200, 2'b11, {5'd8, 5'd8}, {32'h1, 32'h2},
                     1, 32'h110, 2'b11, {5'd9, 5'd4}, {32'h99, 32'h44}, 0, 0, 1);
        tbl[6]  = mk(HOLD, 0, 0, 1, 32'h204, 2'b01, {5'd1, 5'd2}, {32'h3, 32'h4},
                     1, 32'h110, 2'b11, {5'd9, 5'd4}, {32'h99, 32'h44}, 0, 0, 2);
        tbl[7]  = mk(HOLD, 0, 0, 0, 32'h208, 2'b10, {5'd6, 5'd6}, {32'h5, 32'h6},
                     1, 32'h110, 2'b11, {5'd9, 5'd4}, {32'h99, 32'h44}, 0, 0, 3);
        tbl[8]  = mk(BUB, 0, 0, 1, 32'h300, 2'b11, {5'd1, 5'd2}, {32'h7, 32'h8},
                     0, 0, 2'b00, 0, 0, 0, 1, 3);
        tbl[9]  = mk(ADV, 1, 0, 1, 32'h304, 2'b11, {5'd1, 5'd2}, {32'h7, 32'h8},
                     0, 0, 2'b00, 0, 0, 0, 2, 3);
        tbl[10] = mk(HOLD, 1, 0, 1, 32'h308, 2'b11, {5'd1, 5'd2}, {32'h7, 32'h8},
                     0, 0, 2'b00, 0, 0, 0, 3, 3);
        tbl[11] = mk(BUB, 0, 1, 1, 32'h30C, 2'b11, {5'd1, 5'd2}, {32'h7, 32'h8},
                     0, 0, 2'b00, 0, 0, 0, 0, 0);
        tbl[12] = mk(ADV, 0, 0, 1, 32'h400, 2'b11, {5'd31, 5'd30}, {32'hDEAD, 32'hBEEF},
                     1, 32'h400, 2'b11, {5'd31, 5'd30}, {32'hDEAD, 32'hBEEF}, 0, 0, 0);

        drive(zero);
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset", zero);

        for (int i = 0; i < 13; i++) begin
            step($sformatf("tbl%0d", i), tbl[i]);
        end

        // bubble counter saturates at 15 after 20 bubbles
        v = mk(BUB, 0, 0, 1, 32'h500, 2'b01, {5'd0, 5'd1}, {32'h0, 32'h1},
               0, 0, 2'b00, 0, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) begin
            v.e_bub = (i + 1 > 15) ? 4'd15 : 4'(i + 1);
            drive(v);
            @(posedge clk);
            #1;
            if (i == 14 || i == 19) check($sformatf("sat%0d", i), v);
        end

        // clear wins over a simultaneous bubble
        v.clr   = 1'b1;
        v.e_bub = 4'd0;
        step("clr_bub", v);

        // reset in the middle of a hold
        step("pre_hold", tbl[12]);
        v = tbl[5];
        v.e_pc = 32'h400; v.e_wen = 2'b11;
        v.e_waddr = {5'd31, 5'd30}; v.e_wdata = {32'hDEAD, 32'hBEEF};
        v.e_hold = 1;
        step("hold1", v);
        v.e_hold = 2;
        step("hold2", v);
        rst = 1'b1;
        v.e_valid = 0; v.e_pc = 0; v.e_wen = 0; v.e_waddr = 0;
        v.e_wdata = 0; v.e_conf = 0; v.e_bub = 0; v.e_hold = 0;
        step("rst_hold", v);
        rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
